// File: rtl/wb_interconnect.sv
// Wishbone classic shared-bus interconnect: round-robin masters onto base/mask decoded slaves.
// Latency: request in IDLE strobes a slave next cycle; ack and read data return combinationally.
// Backpressure: losing masters stall unacked while the owner holds CYC; stuck slaves time out to ERR.
module wb_interconnect #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT   = 255
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_w,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [N_MASTERS*DATA_W-1:0]   m_dat_r,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [N_SLAVES-1:0]           s_cyc,
  output logic [N_SLAVES-1:0]           s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_w,
  output logic [DATA_W/8-1:0]           s_sel,
  input  logic [N_SLAVES*DATA_W-1:0]    s_dat_r,
  input  logic [N_SLAVES-1:0]           s_ack
);

  localparam int SEL_W = DATA_W / 8;
  localparam int M_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int S_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t           state_q, state_d;
  logic [M_W-1:0]   gnt_q, gnt_d;
  logic [M_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [M_W-1:0]   gnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;

  // Granted master's bus signals
  logic              g_cyc, g_stb, g_we;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_dat_w;
  logic [SEL_W-1:0]  g_sel;

  // Decode results
  logic              hit;
  logic [S_W-1:0]    hit_idx;
  logic [DATA_W-1:0] hit_dat;
  logic              hit_ack;

  // Arbitration results
  logic              req_any;
  logic [M_W-1:0]    req_idx;
  logic [DATA_W-1:0] rdat;

  assign tmo     = (cnt_q == CNT_W'(TIMEOUT));
  assign gnt_inc = (gnt_q == M_W'(N_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
  assign m_dat_r = {N_MASTERS{rdat}};

  // Mux the currently granted master onto the shared internal signals.
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_adr   = '0;
    g_dat_w = '0;
    g_sel   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt_q == M_W'(i)) begin
        g_cyc   = m_cyc[i];
        g_stb   = m_stb[i];
        g_we    = m_we[i];
        g_adr   = m_adr[i*ADDR_W +: ADDR_W];
        g_dat_w = m_dat_w[i*DATA_W +: DATA_W];
        g_sel   = m_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // Address decode; scanning downward makes the lowest-index slave win overlapping windows.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_dat = '0;
    hit_ack = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((g_adr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = S_W'(i);
        hit_dat = s_dat_r[i*DATA_W +: DATA_W];
        hit_ack = s_ack[i];
      end
    end
  end

  // Round-robin pick: the requester closest to rr_ptr (inclusive), wrapping modulo N_MASTERS.
  always_comb begin
    int pos;
    int best_pos;
    req_any  = 1'b0;
    req_idx  = '0;
    pos      = 0;
    best_pos = N_MASTERS;
    for (int i = 0; i < N_MASTERS; i++) begin
      pos = i - int'(rr_ptr_q);
      if (pos < 0) pos = pos + N_MASTERS;
      if (m_cyc[i] && m_stb[i] && (pos < best_pos)) begin
        best_pos = pos;
        req_any  = 1'b1;
        req_idx  = M_W'(i);
      end
    end
  end

  // Next-state: grant, bus lock while CYC held, release, decode error and stuck-slave timeout.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          gnt_d   = req_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_inc;
        end else if (tmo) begin
          state_d = ERR;
        end else if (g_stb && !hit) begin
          state_d = ERR;
        end else if (g_stb && !hit_ack) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        if (g_cyc) begin
          state_d = BUSY;
        end else begin
          state_d  = IDLE;
          rr_ptr_d = gnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs: only BUSY drives slaves; the timeout cycle suppresses strobes and any late ack.
  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m_ack   = '0;
    m_err   = '0;
    rdat    = '0;
    if (state_q == BUSY) begin
      s_we    = g_we;
      s_adr   = g_adr;
      s_dat_w = g_dat_w;
      s_sel   = g_sel;
      if (hit && !tmo) begin
        rdat = hit_dat;
        for (int i = 0; i < N_SLAVES; i++) begin
          if (hit_idx == S_W'(i)) begin
            s_cyc[i] = g_cyc;
            s_stb[i] = g_stb;
          end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
          if (gnt_q == M_W'(i)) m_ack[i] = hit_ack & g_cyc & g_stb;
        end
      end
    end else if (state_q == ERR) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gnt_q == M_W'(i)) m_err[i] = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Bench for wb_interconnect: two masters, three slaves (RAM, UART, overlapping ROM window).
// Latency: checks strobe/ack/err timing cycle by cycle plus a table of single transfers.
// Backpressure: slaves ack combinationally unless disabled; a forced late ack probes the timeout path.
module tb_wb_interconnect;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam logic [NS*32-1:0] BASES = {32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [31:0] KEY [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  logic            sys_clk;
  logic            sys_rst_n;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [NM*32-1:0] m_adr, m_dat_w, m_dat_r;
  logic [NM*4-1:0] m_sel;
  logic [NM-1:0]   m_ack, m_err;
  logic [NS-1:0]   s_cyc, s_stb, s_ack;
  logic            s_we;
  logic [31:0]     s_adr, s_dat_w;
  logic [3:0]      s_sel;
  logic [NS*32-1:0] s_dat_r;
  logic [NS-1:0]   ack_en, ack_force;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] dat;
    bit          chkd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          m;
    logic [31:0] adr;
    bit          we;
    logic [31:0] wd;
    bit          err;
    logic [31:0] dat;
    logic [2:0]  stb;
  } vec_t;
  vec_t vecs[10];
  logic [31:0] lock_dat[4];

  wb_interconnect #(
    .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
    .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r), .s_ack(s_ack)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Slave models: combinational ack when enabled, read data derived from the address.
  assign s_ack = (ack_en & s_cyc & s_stb) | ack_force;
  always_comb begin
    s_dat_r = '0;
    for (int i = 0; i < NS; i++) s_dat_r[i*32 +: 32] = s_adr ^ KEY[i];
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void push(input int m, input bit err, input logic [31:0] dat, input bit chkd);
    exp_t e;
    e.m = m; e.err = err; e.dat = dat; e.chkd = chkd;
    sb.push_back(e);
  endfunction

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge sys_clk);
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input logic [31:0] adr,
                       input bit we, input logic [31:0] wd);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_we[m]  = we;
    m_adr[m*32 +: 32]   = adr;
    m_dat_w[m*32 +: 32] = wd;
    m_sel[m*4 +: 4]     = we ? 4'h3 : 4'hF;
  endtask

  // Scoreboard monitor: every termination must match the next expected record.
  int   mon_who;
  bit   mon_multi;
  exp_t mon_e;
  always @(negedge sys_clk) begin
    if ((m_ack | m_err) != '0) begin
      mon_who   = -1;
      mon_multi = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (m_ack[i] || m_err[i]) begin
          if (mon_who >= 0) mon_multi = 1'b1;
          mon_who = i;
        end
      end
      if (mon_multi || ((m_ack & m_err) != '0)) begin
        checks++;
        failures++;
        $display("FAIL term_single ack=%b err=%b required one master, ack xor err", m_ack, m_err);
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_term ack=%b err=%b required none", m_ack, m_err);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_master", 64'(mon_who), 64'(mon_e.m));
        chk("sb_err", m_err[mon_who], mon_e.err);
        if (mon_e.chkd) chk("sb_rdata", m_dat_r[mon_who*32 +: 32], mon_e.dat);
      end
    end
  end

  task automatic do_xfer(input vec_t v, input int idx);
    bit done;
    done = 1'b0;
    push(v.m, v.err, v.dat, !v.we && !v.err);
    set_m(v.m, 1'b1, 1'b1, v.adr, v.we, v.wd);
    for (int c = 0; c < 40 && !done; c++) begin
      mid();
      if (m_ack[v.m] || m_err[v.m]) begin
        done = 1'b1;
        chk($sformatf("vec%0d_err", idx), m_err[v.m], v.err);
        chk($sformatf("vec%0d_stb", idx), s_stb, v.stb);
        if (!v.err) begin
          chk($sformatf("vec%0d_adr", idx), s_adr, v.adr);
          chk($sformatf("vec%0d_we", idx), s_we, v.we);
          chk($sformatf("vec%0d_sel", idx), s_sel, v.we ? 4'h3 : 4'hF);
          if (v.we) chk($sformatf("vec%0d_wdat", idx), s_dat_w, v.wd);
        end
      end
      nxt();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL vec%0d_timeout no termination seen, required ack or err", idx);
      void'(sb.pop_back());
    end
    set_m(v.m, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nxt();
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h0000_0010, 1'b0, 32'h0,         1'b0, 32'h1111_1101, 3'b001};
    vecs[1] = '{1, 32'h1000_0004, 1'b0, 32'h0,         1'b0, 32'h3222_2226, 3'b010};
    vecs[2] = '{0, 32'h0100_0100, 1'b0, 32'h0,         1'b0, 32'h3233_3233, 3'b100};
    vecs[3] = '{1, 32'h0000_FFFC, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         3'b001};
    vecs[4] = '{0, 32'h8000_0000, 1'b0, 32'h0,         1'b1, 32'h0,         3'b000};
    vecs[5] = '{1, 32'h1001_0000, 1'b0, 32'h0,         1'b1, 32'h0,         3'b000};
    vecs[6] = '{0, 32'h0000_FFFF, 1'b0, 32'h0,         1'b0, 32'h1111_EEEE, 3'b001};
    vecs[7] = '{1, 32'h0FFF_0000, 1'b0, 32'h0,         1'b0, 32'h3CCC_3333, 3'b100};
    vecs[8] = '{0, 32'h1000_00F0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         3'b010};
    vecs[9] = '{1, 32'h2000_0000, 1'b0, 32'h0,         1'b1, 32'h0,         3'b000};
    lock_dat[0] = 32'h1111_1131;
    lock_dat[1] = 32'h1111_1135;
    lock_dat[2] = 32'h1111_1139;
    lock_dat[3] = 32'h1111_113D;

    sys_rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
    ack_en = 3'b111;
    ack_force = '0;
    nxt();
    nxt();
    // Reset state
    mid();
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_dat_w", s_dat_w, 0);
    chk("rst_s_sel", s_sel, 0);
    chk("rst_m_dat_r", m_dat_r, 0);
    nxt();
    sys_rst_n = 1'b1;
    nxt();

    // Arbitration from reset, turnaround and round-robin alternation
    set_m(0, 1, 1, 32'h0000_0010, 0, 0);
    set_m(1, 1, 1, 32'h1000_0004, 0, 0);
    mid(); chk("arb_req_stb", s_stb, 0); chk("arb_req_ack", m_ack, 0);
    nxt(); push(0, 0, 32'h1111_1101, 1);
    mid(); chk("arb_m0_stb", s_stb, 3'b001); chk("arb_m0_ack", m_ack, 2'b01);
    nxt(); set_m(0, 0, 0, 32'h0, 0, 0);
    mid(); chk("arb_rel_cyc", s_cyc, 0); chk("arb_rel_ack", m_ack, 0);
    nxt(); set_m(0, 1, 1, 32'h0000_0010, 0, 0);
    mid(); chk("arb_idle_stb", s_stb, 0);
    nxt(); push(1, 0, 32'h3222_2226, 1);
    mid(); chk("arb_m1_stb", s_stb, 3'b010); chk("arb_m1_ack", m_ack, 2'b10);
    nxt(); set_m(1, 0, 0, 32'h0, 0, 0);
    mid(); chk("arb_rel1_ack", m_ack, 0);
    nxt();
    mid(); chk("arb_idle2_stb", s_stb, 0);
    nxt(); push(0, 0, 32'h1111_1101, 1);
    mid(); chk("arb_m0b_stb", s_stb, 3'b001); chk("arb_m0b_ack", m_ack, 2'b01);
    nxt(); set_m(0, 0, 0, 32'h0, 0, 0);
    nxt();
    nxt();

    // Bus lock: four strobes by master 0 while master 1 waits
    set_m(0, 1, 1, 32'h0000_0020, 0, 0);
    nxt();
    set_m(1, 1, 1, 32'h1000_0008, 0, 0);
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1, 1, 32'h0000_0020 + 32'(4 * k), 0, 0);
      push(0, 0, lock_dat[k], 1);
      mid(); chk($sformatf("lock%0d_ack", k), m_ack, 2'b01); chk($sformatf("lock%0d_err", k), m_err, 0);
      nxt();
    end
    set_m(0, 0, 0, 32'h0, 0, 0);
    mid(); chk("lock_rel_ack", m_ack, 0); chk("lock_rel_err", m_err, 0);
    nxt();
    mid(); chk("lock_idle_stb", s_stb, 0); chk("lock_idle_ack", m_ack, 0);
    nxt(); push(1, 0, 32'h3222_222A, 1);
    mid(); chk("lock_m1_stb", s_stb, 3'b010); chk("lock_m1_ack", m_ack, 2'b10);
    nxt(); set_m(1, 0, 0, 32'h0, 0, 0);
    nxt();
    nxt();

    // Unmapped access, then the bus serves the next request
    set_m(1, 1, 1, 32'h8000_0000, 0, 0);
    nxt();
    mid(); chk("unm_stb", s_stb, 0); chk("unm_early_err", m_err, 0);
    nxt(); push(1, 1, 32'h0, 0);
    mid(); chk("unm_err", m_err, 2'b10); chk("unm_ack", m_ack, 0); chk("unm_err_stb", s_stb, 0);
    nxt(); set_m(1, 0, 0, 32'h0, 0, 0);
    mid(); chk("unm_err_once", m_err, 0);
    nxt(); set_m(0, 1, 1, 32'h0000_0010, 0, 0);
    nxt(); push(0, 0, 32'h1111_1101, 1);
    mid(); chk("unm_next_ack", m_ack, 2'b01);
    nxt(); set_m(0, 0, 0, 32'h0, 0, 0);
    nxt();
    nxt();

    // Stuck slave: TIMEOUT=8, error 9 cycles after the first strobe, late ack ignored
    ack_en[0] = 1'b0;
    set_m(0, 1, 1, 32'h0000_0040, 0, 0);
    nxt();
    for (int k = 0; k < 8; k++) begin
      mid(); chk($sformatf("tmo_wait%0d_stb", k), s_stb, 3'b001); chk($sformatf("tmo_wait%0d_err", k), m_err, 0);
      nxt();
    end
    ack_force[0] = 1'b1;
    mid(); chk("tmo_cut_stb", s_stb, 0); chk("tmo_cut_ack", m_ack, 0); chk("tmo_cut_err", m_err, 0);
    nxt(); push(0, 1, 32'h0, 0);
    mid(); chk("tmo_err", m_err, 2'b01); chk("tmo_err_ack", m_ack, 0); chk("tmo_err_stb", s_stb, 0);
    nxt(); set_m(0, 0, 0, 32'h0, 0, 0);
    mid(); chk("tmo_late_ack", m_ack, 0);
    nxt();
    ack_force[0] = 1'b0;
    ack_en[0] = 1'b1;
    nxt();

    // Reset mid-BUSY: outputs clear, rr pointer back to master 0
    ack_en[1] = 1'b0;
    set_m(1, 1, 1, 32'h1000_0000, 0, 0);
    nxt();
    sys_rst_n = 1'b0;
    set_m(0, 1, 1, 32'h0000_0010, 0, 0);
    mid(); chk("rmid_busy_stb", s_stb, 3'b010);
    nxt();
    sys_rst_n = 1'b1;
    mid();
    chk("rmid_s_cyc", s_cyc, 0);
    chk("rmid_s_stb", s_stb, 0);
    chk("rmid_m_ack", m_ack, 0);
    chk("rmid_m_err", m_err, 0);
    chk("rmid_s_adr", s_adr, 0);
    chk("rmid_m_dat_r", m_dat_r, 0);
    nxt(); push(0, 0, 32'h1111_1101, 1);
    mid(); chk("rmid_regrant_stb", s_stb, 3'b001); chk("rmid_regrant_ack", m_ack, 2'b01);
    nxt();
    set_m(0, 0, 0, 32'h0, 0, 0);
    set_m(1, 0, 0, 32'h0, 0, 0);
    ack_en[1] = 1'b1;
    nxt();
    nxt();

    // Table-driven single transfers
    for (int i = 0; i < 10; i++) do_xfer(vecs[i], i);

    nxt();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
# wb_interconnect

Parametrised Wishbone shared-bus interconnect connecting N_MASTERS classic-cycle masters (CPU fetch, CPU LSU, future DMA) to N_SLAVES address-decoded slaves (ROM, RAM, UART, …). Replaces the fixed one-master, two-slave switch in the SoC top. Adds the following over that switch:
- round-robin master arbitration with bus locking while CYC is held;
- configurable base/mask address decode;
- an error response for unmapped addresses;
- a stuck-slave timeout.

## Interface
- N_MASTERS, 2: number of master ports (1..8).
- N_SLAVES, 3: number of slave ports (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; SEL width is DATA_W/8.
- SLAVE_BASE, {N_SLAVES{ADDR_W'0}}: packed bases; slice i = base of slave i.
- SLAVE_MASK, {N_SLAVES{ADDR_W'0}}: packed masks; slave i hits when (adr & MASK[i]) == BASE[i].
- TIMEOUT, 255: maximum cycles a strobe waits for ACK before an error (≥2).
- sys_clk  in  1  single clock; all logic on the rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- m_cyc, m_stb, m_we  in  N_MASTERS each  per-master bus signals.
- m_adr  in  N_MASTERS*ADDR_W  packed master addresses.
- m_dat_w  in  N_MASTERS*DATA_W  packed master write data.
- m_sel  in  N_MASTERS*DATA_W/8  packed byte selects.
- m_dat_r  out  N_MASTERS*DATA_W  read data; same slave data broadcast to all slices.
- m_ack, m_err  out  N_MASTERS each  termination, asserted only to the granted master.
- s_cyc, s_stb  out  N_SLAVES each  one-hot per slave.
- s_we  out  1  shared write enable.
- s_adr  out  ADDR_W  shared address.
- s_dat_w  out  DATA_W  shared write data.
- s_sel  out  DATA_W/8  shared byte selects.
- s_dat_r  in  N_SLAVES*DATA_W  packed slave read data.
- s_ack  in  N_SLAVES  per-slave acknowledge.

## Operation
- FSM states: IDLE, BUSY, ERR.

IDLE
- Requesters = m_cyc & m_stb.
- If any requester exists, grant the first one found scanning from rr_ptr upward, wrapping modulo N_MASTERS.
- Register gnt (index) and go to BUSY.

BUSY
- Shared slave outputs (s_we/s_adr/s_dat_w/s_sel) = granted master's signals, combinationally.
- Decode on the granted m_adr. Overlapping windows resolve to the lowest-index slave.
  - Hit slave h: s_cyc[h] = m_cyc[gnt], s_stb[h] = m_stb[gnt]. All other slave strobes are 0.
  - m_ack[gnt] = s_ack[h] combinationally; m_dat_r = s_dat_r slice h.
  - No hit and m_stb[gnt]: no slave is strobed; go to ERR.
- Timeout counter (width clog2(TIMEOUT+1)):
  - clears on any ACK, on m_stb[gnt] = 0, and on entering BUSY;
  - increments each cycle m_stb[gnt] = 1 with no ACK;
  - on reaching TIMEOUT, go to ERR; s_cyc/s_stb are forced to 0 in that cycle.
- m_cyc[gnt] = 0: release. Set rr_ptr = gnt+1 (wraps), go to IDLE. All s_cyc drop the same cycle. A late s_ack is ignored.
- Back-to-back strobes under the same CYC keep the grant (bus lock). Other masters stall with no ack.

ERR
- m_err[gnt] = 1 for exactly one cycle; no slave strobed; counter cleared.
- Next state: BUSY if m_cyc[gnt] is still 1, otherwise IDLE with rr_ptr advanced.

Other rules
- m_ack and m_err are never asserted together, and never to a non-granted master.
- ACK received in IDLE or ERR is dropped.
- Reset: state = IDLE, rr_ptr = 0, gnt = 0, counter = 0. All m_ack/m_err/s_cyc/s_stb = 0. m_dat_r, s_adr, s_dat_w, s_sel, s_we = 0.
- Reset mid-transaction: everything is cleared at the next edge; the interrupted transfer is neither acked nor errored.

## Timing
- Arbitration latency: a request in IDLE at cycle N reaches a slave strobe at cycle N+1.
- ACK return latency: 0 cycles (combinational s_ack → m_ack).
- Single-cycle-ack slave: first transfer completes at N+1. Each further locked strobe completes in the cycle the slave acks.
- Unmapped access: strobe seen at cycle B, m_err at B+1.
- Timeout: strobe from cycle B with no ack gives m_err at B+TIMEOUT+1.
- Grant turnaround: master releases CYC at cycle R; a waiting master is granted at R+1 and strobes a slave at R+2.

## Test plan
- Single master, RAM at base 0x0000_0000 mask 0xFFFF_0000: read 0x0000_0010 with 1-cycle ack → s_stb[0] at N+1, m_ack[0] with RAM data the same cycle, nothing on s_stb[1..].
- Both masters request at cycle N from reset → master 0 granted. After it drops CYC, master 1 is granted the next cycle. Repeat with both requesting again → master 0 and master 1 alternate.
- Master 0 holds CYC across 4 strobes while master 1 requests → 4 acks to master 0, no ack or err to master 1, master 1 granted only after release.
- Access to 0x8000_0000 with no slave mapped there → no s_stb, m_err one cycle later, then the bus is usable by the next request.
- TIMEOUT = 8, slave never acks → m_err exactly 9 cycles after the strobe. s_stb deasserted in the error cycle. A late s_ack is not forwarded.
- sys_rst_n low for one cycle mid-BUSY → all outputs 0 next cycle, state IDLE, next grant starts from master 0.
